// File: rtl/pc_pkg.sv
// Shared types and defaults for the fetch PC generator.
// Holds the FSM state encoding, the next-PC select and event codes, and the parameter defaults.
package pc_pkg;

    localparam int unsigned XLEN_DEF      = 32;
    localparam int unsigned INC_DEF       = 4;
    localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC_DEF  = 32'h0000_0100;

    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10,
        ST_TRAP = 2'b11
    } pc_state_e;

    typedef enum logic [1:0] {
        SEL_HOLD   = 2'd0,
        SEL_INC    = 2'd1,
        SEL_TARGET = 2'd2,
        SEL_TRAP   = 2'd3
    } pc_sel_e;

    typedef enum logic [1:0] {
        EVT_NONE     = 2'd0,
        EVT_TRAP     = 2'd1,
        EVT_MISALIGN = 2'd2,
        EVT_REDIR    = 2'd3
    } pc_evt_e;

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-side bundle of pc_gen: pipeline control in, fetch request and status out.
// Signal suffixes are relative to pc_gen, which uses the slave modport.
interface pc_gen_if #(
    parameter int unsigned XLEN = pc_pkg::XLEN_DEF
);
    logic            stall_i;
    logic            redir_valid_i;
    logic [XLEN-1:0] redir_target_i;
    logic            trap_i;
    logic            halt_i;
    logic            resume_i;
    logic            fetch_ready_i;
    logic [XLEN-1:0] pc_o;
    logic            fetch_valid_o;
    logic            flush_o;
    logic            misalign_o;
    logic [1:0]      state_o;

    modport master (
        output stall_i, redir_valid_i, redir_target_i, trap_i, halt_i, resume_i, fetch_ready_i,
        input  pc_o, fetch_valid_o, flush_o, misalign_o, state_o
    );

    modport slave (
        input  stall_i, redir_valid_i, redir_target_i, trap_i, halt_i, resume_i, fetch_ready_i,
        output pc_o, fetch_valid_o, flush_o, misalign_o, state_o
    );

endinterface

// File: rtl/pc_next_sel.sv
// Next-PC mux: hold, increment (wrapping), redirect target or trap vector; flags unaligned targets.
// Purely combinational, no backpressure of its own.
module pc_next_sel
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN     = XLEN_DEF,
    parameter int unsigned     INC      = INC_DEF,
    parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(TRAP_VEC_DEF)
) (
    input  pc_sel_e         sel_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] target_i,
    output logic [XLEN-1:0] nxt_pc_o,
    output logic            misalign_o
);

    localparam logic [XLEN-1:0] INC_W      = XLEN'(INC);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INC - 1);

    assign misalign_o = (target_i & ALIGN_MASK) != '0;

    always_comb begin
        nxt_pc_o = pc_i;
        case (sel_i)
            SEL_HOLD:   nxt_pc_o = pc_i;
            SEL_INC:    nxt_pc_o = pc_i + INC_W;
            SEL_TARGET: nxt_pc_o = target_i;
            SEL_TRAP:   nxt_pc_o = TRAP_VEC;
            default:    nxt_pc_o = pc_i;
        endcase
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator FSM (BOOT/RUN/HALT/TRAP); every output is registered, so changes show one cycle later.
// The PC advances only on an accepted fetch; redirects and traps ignore stall_i and fetch_ready_i.
module pc_gen
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN      = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(RESET_VEC_DEF),
    parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(TRAP_VEC_DEF),
    parameter int unsigned     INC       = INC_DEF
) (
    input logic    clk,
    input logic    rst,
    pc_gen_if.slave bus
);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            fetch_valid_q, fetch_valid_d;
    logic            flush_q, flush_d;
    logic            misalign_q, misalign_d;
    pc_sel_e         pc_sel;
    pc_evt_e         evt;
    logic            tgt_misaligned;

    pc_next_sel #(
        .XLEN     (XLEN),
        .INC      (INC),
        .TRAP_VEC (TRAP_VEC)
    ) u_next_sel (
        .sel_i      (pc_sel),
        .pc_i       (pc_q),
        .target_i   (bus.redir_target_i),
        .nxt_pc_o   (pc_d),
        .misalign_o (tgt_misaligned)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_VEC;
            fetch_valid_q <= 1'b0;
            flush_q       <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_valid_q <= fetch_valid_d;
            flush_q       <= flush_d;
            misalign_q    <= misalign_d;
        end
    end

    // Priority inside RUN: trap > misaligned redirect > redirect > halt > stall > advance.
    always_comb begin
        state_d = state_q;
        pc_sel  = SEL_HOLD;
        evt     = EVT_NONE;
        case (state_q)
            ST_BOOT, ST_TRAP: begin
                if (bus.trap_i) begin
                    state_d = ST_TRAP;
                    pc_sel  = SEL_TRAP;
                    evt     = EVT_TRAP;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.trap_i) begin
                    state_d = ST_TRAP;
                    pc_sel  = SEL_TRAP;
                    evt     = EVT_TRAP;
                end else if (bus.redir_valid_i && tgt_misaligned) begin
                    state_d = ST_TRAP;
                    pc_sel  = SEL_TRAP;
                    evt     = EVT_MISALIGN;
                end else if (bus.redir_valid_i) begin
                    pc_sel  = SEL_TARGET;
                    evt     = EVT_REDIR;
                end else if (bus.halt_i) begin
                    state_d = ST_HALT;
                end else if (!bus.stall_i && bus.fetch_ready_i) begin
                    pc_sel  = SEL_INC;
                end
            end
            ST_HALT: begin
                if (bus.trap_i) begin
                    state_d = ST_TRAP;
                    pc_sel  = SEL_TRAP;
                    evt     = EVT_TRAP;
                end else if (bus.redir_valid_i) begin
                    pc_sel  = SEL_TARGET;
                    evt     = EVT_REDIR;
                end else if (bus.resume_i) begin
                    state_d = ST_RUN;
                end
            end
        endcase
    end

    always_comb begin
        fetch_valid_d = (state_d == ST_RUN);
        flush_d       = (evt != EVT_NONE);
        misalign_d    = (evt == EVT_MISALIGN);
    end

    assign bus.pc_o          = pc_q;
    assign bus.fetch_valid_o = fetch_valid_q;
    assign bus.flush_o       = flush_q;
    assign bus.misalign_o    = misalign_q;
    assign bus.state_o       = state_q;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed scenarios followed by random traffic, all checked against a cycle-level behavioural model.
module tb_pc_gen;

    localparam int BOOT = 0;
    localparam int RUN  = 1;
    localparam int HALT = 2;
    localparam int TRAP = 3;
    localparam longint TRAP_ADDR = 64'h100;
    localparam longint WRAP      = 64'h1_0000_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pc_gen_if #(.XLEN(32)) bus ();

    pc_gen #(
        .XLEN      (32),
        .RESET_VEC (32'h0000_0000),
        .TRAP_VEC  (32'h0000_0100),
        .INC       (4)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int     n_cmp = 0;
    int     n_bad = 0;
    longint m_pc;
    int     m_mode;
    bit     m_flush;
    bit     m_mis;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drv(input bit r, input bit stall, input bit rv, input logic [31:0] tgt,
                       input bit trap, input bit halt, input bit resume, input bit ready);
        rst                = r;
        bus.stall_i        = stall;
        bus.redir_valid_i  = rv;
        bus.redir_target_i = tgt;
        bus.trap_i         = trap;
        bus.halt_i         = halt;
        bus.resume_i       = resume;
        bus.fetch_ready_i  = ready;
    endtask

    task automatic take_trap();
        m_pc    = TRAP_ADDR;
        m_mode  = TRAP;
        m_flush = 1'b1;
    endtask

    // What the block should do at the coming edge, straight from the behavioural rules.
    task automatic model_step();
        longint tgt;
        tgt     = longint'(bus.redir_target_i);
        m_flush = 1'b0;
        m_mis   = 1'b0;
        if (rst) begin
            m_pc   = 0;
            m_mode = BOOT;
        end else if (m_mode == BOOT || m_mode == TRAP) begin
            if (bus.trap_i) take_trap();
            else m_mode = RUN;
        end else if (m_mode == RUN) begin
            if (bus.trap_i) take_trap();
            else if (bus.redir_valid_i && (tgt % 4) != 0) begin
                take_trap();
                m_mis = 1'b1;
            end else if (bus.redir_valid_i) begin
                m_pc    = tgt;
                m_flush = 1'b1;
            end else if (bus.halt_i) m_mode = HALT;
            else if (!bus.stall_i && bus.fetch_ready_i) m_pc = (m_pc + 4) % WRAP;
        end else begin
            if (bus.trap_i) take_trap();
            else if (bus.redir_valid_i) begin
                m_pc    = tgt;
                m_flush = 1'b1;
            end else if (bus.resume_i) m_mode = RUN;
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check("pc", bus.pc_o, 32'(m_pc));
        check("fetch_valid", 32'(bus.fetch_valid_o), 32'(m_mode == RUN));
        check("flush", 32'(bus.flush_o), 32'(m_flush));
        check("misalign", 32'(bus.misalign_o), 32'(m_mis));
        check("state", 32'(bus.state_o), 32'(m_mode));
    endtask

    initial begin
        m_pc = 0; m_mode = BOOT; m_flush = 0; m_mis = 0;
        drv(1, 0, 0, 32'h0, 0, 0, 0, 0);

        // Reset, one BOOT cycle, then four sequential fetches.
        step();
        check("reset_state", 32'(bus.state_o), 32'(BOOT));
        check("reset_fv", 32'(bus.fetch_valid_o), 32'h0);
        drv(0, 0, 0, 32'h0, 0, 0, 0, 1);
        step();
        check("boot_pc0", bus.pc_o, 32'h0);
        check("boot_fv", 32'(bus.fetch_valid_o), 32'h1);
        step(); check("seq_pc4", bus.pc_o, 32'h4);
        step(); check("seq_pc8", bus.pc_o, 32'h8);
        step(); check("seq_pcC", bus.pc_o, 32'hC);
        step(); check("seq_pc10", bus.pc_o, 32'h10);

        // Redirect under stall.
        drv(0, 1, 1, 32'h200, 0, 0, 0, 1);
        step();
        check("redir_pc", bus.pc_o, 32'h200);
        check("redir_flush", 32'(bus.flush_o), 32'h1);
        drv(0, 0, 0, 32'h0, 0, 0, 0, 0);
        step();
        check("redir_flush_once", 32'(bus.flush_o), 32'h0);

        // Misaligned redirect.
        drv(0, 0, 1, 32'h202, 0, 0, 0, 1);
        step();
        check("mis_pc", bus.pc_o, 32'h100);
        check("mis_flag", 32'(bus.misalign_o), 32'h1);
        check("mis_state", 32'(bus.state_o), 32'(TRAP));
        drv(0, 0, 0, 32'h0, 0, 0, 0, 0);
        step();
        check("mis_run_pc", bus.pc_o, 32'h100);
        check("mis_run_fv", 32'(bus.fetch_valid_o), 32'h1);

        // Halt at 0x40, then resume with halt still asserted.
        drv(0, 0, 1, 32'h40, 0, 0, 0, 1);
        step();
        drv(0, 0, 0, 32'h0, 0, 1, 0, 1);
        step();
        check("halt_pc", bus.pc_o, 32'h40);
        check("halt_fv", 32'(bus.fetch_valid_o), 32'h0);
        step();
        check("halt_hold_pc", bus.pc_o, 32'h40);
        drv(0, 0, 0, 32'h0, 0, 1, 1, 1);
        step();
        check("resume_state", 32'(bus.state_o), 32'(RUN));
        check("resume_pc", bus.pc_o, 32'h40);

        // Wrap at the top of the address space.
        drv(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 1);
        step();
        drv(0, 0, 0, 32'h0, 0, 0, 0, 1);
        step();
        check("wrap_pc", bus.pc_o, 32'h0);
        check("wrap_flush", 32'(bus.flush_o), 32'h0);

        // Reset wins over a simultaneous trap; no flush after release.
        drv(1, 0, 0, 32'h0, 1, 0, 0, 1);
        step();
        check("rst_trap_pc", bus.pc_o, 32'h0);
        check("rst_trap_state", 32'(bus.state_o), 32'(BOOT));
        check("rst_trap_flush", 32'(bus.flush_o), 32'h0);
        drv(0, 0, 0, 32'h0, 0, 0, 0, 1);
        step();
        check("post_rst_flush", 32'(bus.flush_o), 32'h0);

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] tg;
            tg = $urandom;
            if ($urandom_range(3, 0) != 0) tg[1:0] = 2'b00;
            drv($urandom_range(63, 0) == 0, $urandom_range(3, 0) == 0, $urandom_range(7, 0) == 0, tg,
                $urandom_range(15, 0) == 0, $urandom_range(9, 0) == 0, $urandom_range(3, 0) == 0,
                $urandom_range(3, 0) != 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; ports SHALL be named clk and rst.
REQ-002 Parameter XLEN, 32, PC width in bits.
REQ-003 Parameter RESET_VEC, 32'h0000_0000, PC value loaded on reset.
REQ-004 Parameter TRAP_VEC, 32'h0000_0100, PC value loaded on trap or misaligned redirect.
REQ-005 Parameter INC, 4, byte increment per accepted fetch.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 stall_i  in  1  hold PC (hazard unit).
REQ-009 redir_valid_i  in  1  taken branch/jump from EX.
REQ-010 redir_target_i  in  XLEN  redirect target address.
REQ-011 trap_i  in  1  exception request.
REQ-012 halt_i  in  1  request halt.
REQ-013 resume_i  in  1  leave halt.
REQ-014 fetch_ready_i  in  1  instruction memory accepts pc_o.
REQ-015 pc_o  out  XLEN  current fetch address (registered).
REQ-016 fetch_valid_o  out  1  pc_o is a valid fetch request.
REQ-017 flush_o  out  1  one-cycle pulse: kill IF/ID contents.
REQ-018 misalign_o  out  1  one-cycle pulse: redirect target not INC-aligned.
REQ-019 state_o  out  2  FSM state.

Function
REQ-020 FSM states SHALL be BOOT=2'b00, RUN=2'b01, HALT=2'b10, TRAP=2'b11.
REQ-021 BOOT SHALL last exactly one cycle, fetch_valid_o=0, then go to RUN with pc_o unchanged.
REQ-022 fetch_valid_o SHALL be 1 only in RUN; all outputs SHALL be registered.
REQ-023 RUN priority per cycle: trap_i > misaligned redirect > redir_valid_i > halt_i > stall_i > sequential advance.
REQ-024 Sequential advance: pc_o <= pc_o + INC only when fetch_valid_o && fetch_ready_i && !stall_i; otherwise hold; sum SHALL wrap modulo 2^XLEN.
REQ-025 Aligned redirect: next edge pc_o <= redir_target_i and flush_o=1 for that one cycle; stall_i and fetch_ready_i SHALL NOT delay it.
REQ-026 Misaligned redirect (redir_target_i[1:0]!=0): next edge pc_o <= TRAP_VEC, misalign_o=1 and flush_o=1 for one cycle, state -> TRAP.
REQ-027 trap_i: next edge pc_o <= TRAP_VEC, flush_o=1 for one cycle, state -> TRAP.
REQ-028 TRAP SHALL last one cycle with fetch_valid_o=0, then -> RUN.
REQ-029 halt_i in RUN (no higher-priority event): state -> HALT, pc_o held, fetch_valid_o=0.
REQ-030 In HALT: trap_i -> TRAP per REQ-027; else redir_valid_i loads target (with flush_o) and stays HALT; else resume_i -> RUN; resume_i wins over simultaneous halt_i.
REQ-031 trap_i in TRAP or BOOT SHALL be honoured per REQ-027; redirects in BOOT/TRAP SHALL be ignored.
REQ-032 flush_o and misalign_o SHALL never be high for two consecutive cycles from one event.

Reset
REQ-033 While rst=1 at a rising edge: pc_o=RESET_VEC, state_o=BOOT, fetch_valid_o=0, flush_o=0, misalign_o=0, regardless of other inputs or current state.
REQ-034 Reset asserted mid-redirect or mid-halt SHALL discard the pending event; no flush_o pulse follows reset release.

Structure
REQ-035 Shared package pc_pkg SHALL hold the state encoding typedef, default XLEN, and RESET_VEC/TRAP_VEC defaults.
REQ-036 Next-PC selection SHALL be one combinational sub-module pc_next_sel; FSM and PC register SHALL remain in pc_gen.

Verification
REQ-037 Reset then fetch_ready_i=1 for 4 cycles -> BOOT one cycle, then pc_o 0x0,0x4,0x8,0xC with fetch_valid_o=1.
REQ-038 pc_o=0x10, stall_i=1 and redir_valid_i=1 target 0x200 same cycle -> next pc_o=0x200, flush_o=1 one cycle.
REQ-039 Redirect target 0x202 -> pc_o=0x100, misalign_o=1, flush_o=1, one TRAP cycle with fetch_valid_o=0, then RUN at 0x100.
REQ-040 halt_i at pc_o=0x40 -> pc_o holds 0x40, fetch_valid_o=0; resume_i with halt_i both 1 -> RUN, fetching 0x40.
REQ-041 Parameter XLEN=32, pc_o=0xFFFF_FFFC accepted -> pc_o=0x0000_0000, no flush_o.
REQ-042 rst=1 same cycle as trap_i=1 -> pc_o=RESET_VEC, state BOOT, flush_o=0.
